// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed hex driver for N_DIGITS common-anode seven-segment digits.
// A prescaler divides the clock into digit slots. Each slot selects one digit,
// decodes its nibble and drives that digit's anode. A free-running 4-bit PWM
// counter sets brightness. Loads go into a shadow buffer, which is copied to
// the display registers only when the scan wraps from the last digit to digit
// 0, so a frame never shows a mix of old and new data.
//
// Parameters:
//   N_DIGITS   number of digits scanned (1..16)
//   PRESCALE   clock cycles per digit slot (>= 2)
//   ACTIVE_LOW 1: segments/dp/anodes active-low, 0: active-high
//
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   data_in, dp_in, load   nibble/dp data and capture strobe (digit 0 rightmost)
//   digit_en               per-digit enable mask
//   blank_lz               leading-zero blanking enable
//   brightness             PWM duty (0 = 1/16 .. 15 = always on)
//   segments, dp, anodes   registered display outputs, {g,f,e,d,c,b,a}
//   pending                shadow holds data not yet displayed
//   frame_tick             one-cycle pulse after a commit
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int N_DIGITS   = 8,
  parameter int PRESCALE   = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int IDX_W = $clog2((N_DIGITS > 1) ? N_DIGITS : 2);
  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      4'hF:    seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [PRE_W-1:0]      presc_r;
  logic [IDX_W-1:0]      idx_r;
  logic [3:0]            pwm_r;
  logic [4*N_DIGITS-1:0] shadow_data_r;
  logic [N_DIGITS-1:0]   shadow_dp_r;
  logic [4*N_DIGITS-1:0] disp_data_r;
  logic [N_DIGITS-1:0]   disp_dp_r;
  logic                  pending_r;
  logic                  frame_tick_r;

  logic                  slot_end_s;
  logic                  wrap_s;
  logic                  commit_s;
  logic [N_DIGITS-1:0]   blank_s;
  logic                  zero_above_s;
  logic [3:0]            nib_s;
  logic                  lit_s;
  logic [6:0]            seg_ah_s;
  logic                  dp_ah_s;
  logic [N_DIGITS-1:0]   an_ah_s;

  assign slot_end_s = (presc_r == PRE_LAST);
  assign wrap_s     = slot_end_s && (idx_r == IDX_LAST);
  assign commit_s   = wrap_s && pending_r;

  // Slot prescaler: counts 0..PRESCALE-1 and wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          presc_r <= '0;
    else if (slot_end_s) presc_r <= '0;
    else                 presc_r <= presc_r + PRE_W'(1);
  end

  // Digit index: advances at each slot end; with one digit it stays at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_r <= '0;
    end else if (slot_end_s) begin
      if (idx_r == IDX_LAST) idx_r <= '0;
      else                   idx_r <= idx_r + IDX_W'(1);
    end
  end

  // Free-running brightness PWM counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pwm_r <= 4'd0;
    else        pwm_r <= pwm_r + 4'd1;
  end

  // Shadow/display double buffer. A commit copies the pre-edge shadow, so a
  // load on the same edge lands in the shadow and stays pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_data_r <= '0;
      shadow_dp_r   <= '0;
      disp_data_r   <= '0;
      disp_dp_r     <= '0;
      pending_r     <= 1'b0;
      frame_tick_r  <= 1'b0;
    end else begin
      if (commit_s) begin
        disp_data_r <= shadow_data_r;
        disp_dp_r   <= shadow_dp_r;
      end
      if (load) begin
        shadow_data_r <= data_in;
        shadow_dp_r   <= dp_in;
      end
      pending_r    <= load | (pending_r & ~commit_s);
      frame_tick_r <= commit_s;
    end
  end

  // Leading-zero mask: digit i is blank when every nibble from the top down
  // to i is zero. Digit 0 is never blanked.
  always_comb begin
    blank_s      = '0;
    zero_above_s = blank_lz;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above_s = zero_above_s & (disp_data_r[4*i +: 4] == 4'h0);
      blank_s[i]   = zero_above_s;
    end
  end

  // Active-high pattern for the currently selected digit.
  always_comb begin
    nib_s    = disp_data_r[{idx_r, 2'b00} +: 4];
    lit_s    = digit_en[idx_r] & ~blank_s[idx_r] & (pwm_r <= brightness);
    seg_ah_s = 7'b0000000;
    dp_ah_s  = 1'b0;
    an_ah_s  = '0;
    if (lit_s) begin
      seg_ah_s = hex_to_seg(nib_s);
      dp_ah_s  = disp_dp_r[idx_r];
      an_ah_s  = N_DIGITS'(1) << idx_r;
    end else begin
      seg_ah_s = 7'b0000000;
      dp_ah_s  = 1'b0;
      an_ah_s  = '0;
    end
  end

  // Registered output stage with board polarity applied.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      segments <= {7{POL}};
      dp       <= POL;
      anodes   <= {N_DIGITS{POL}};
    end else begin
      segments <= seg_ah_s ^ {7{POL}};
      dp       <= dp_ah_s ^ POL;
      anodes   <= an_ah_s ^ {N_DIGITS{POL}};
    end
  end

  assign pending    = pending_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Bench for seg7_scan_driver with N_DIGITS=4, PRESCALE=4, ACTIVE_LOW=1.
// A frame-level model derives the scan position and PWM phase from the cycle
// count since reset and tracks the shadow/display buffers; a compare process
// checks every output on every falling edge. Directed sequences add literal
// expectations for reset, decode, tear-free loading, blanking, brightness and
// a load that coincides with a commit.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int   N  = 4;
  localparam int   P  = 4;
  localparam logic AL = 1'b1;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  anodes;
  logic        pending;
  logic        frame_tick;

  int vectors     = 0;
  int miscompares = 0;

  seg7_scan_driver #(.N_DIGITS(N), .PRESCALE(P), .ACTIVE_LOW(1)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .dp_in(dp_in),
    .load(load), .digit_en(digit_en), .blank_lz(blank_lz),
    .brightness(brightness), .segments(segments), .dp(dp), .anodes(anodes),
    .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          m_cyc = 0;
  int          m_idx;
  int          m_pwm;
  logic        m_blank, m_lit, m_commit;
  logic [3:0]  m_nib;
  logic [15:0] m_shadow = '0, m_disp = '0;
  logic [3:0]  m_sdp = '0, m_ddp = '0;
  logic        m_pend = 1'b0;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;
  logic [3:0]  exp_an = 4'hF;
  logic        exp_pend = 1'b0;
  logic        exp_tick = 1'b0;

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_cyc = 0; m_shadow = '0; m_sdp = '0; m_disp = '0; m_ddp = '0; m_pend = 1'b0;
        exp_seg = {7{AL}}; exp_dp = AL; exp_an = {4{AL}}; exp_pend = 1'b0; exp_tick = 1'b0;
      end else begin
        m_idx   = (m_cyc / P) % N;
        m_pwm   = m_cyc % 16;
        m_blank = blank_lz && (m_idx != 0) && ((m_disp >> (4 * m_idx)) == 16'h0000);
        m_lit   = digit_en[m_idx] && !m_blank && (m_pwm <= int'(brightness));
        if (m_lit) begin
          m_nib   = m_disp[4*m_idx +: 4];
          exp_seg = ref_seg(m_nib) ^ {7{AL}};
          exp_dp  = m_ddp[m_idx] ^ AL;
          exp_an  = (4'b0001 << m_idx) ^ {4{AL}};
        end else begin
          exp_seg = {7{AL}}; exp_dp = AL; exp_an = {4{AL}};
        end
        m_commit = ((m_cyc % (P * N)) == (P * N - 1)) && m_pend;
        exp_tick = m_commit;
        if (m_commit) begin
          m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0;
        end
        if (load) begin
          m_shadow = data_in; m_sdp = dp_in; m_pend = 1'b1;
        end
        exp_pend = m_pend;
        m_cyc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock);
      chk("m_segments", 16'(segments), 16'(exp_seg));
      chk("m_dp", 16'(dp), 16'(exp_dp));
      chk("m_anodes", 16'(anodes), 16'(exp_an));
      chk("m_pending", 16'(pending), 16'(exp_pend));
      chk("m_frame_tick", 16'(frame_tick), 16'(exp_tick));
    end
  end

  // ---------------- directed ----------------
  task automatic wait_tick(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (frame_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, 16'(found), 16'd1);
  endtask

  // Count over 16 cycles: cycles with any anode low, with anode k low, and
  // the segment value seen while anode 0 was low.
  task automatic window(input int k, output int any_low, output int k_low,
                        output int up_low, output logic [6:0] seg0);
    any_low = 0; k_low = 0; up_low = 0; seg0 = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (anodes != 4'hF) any_low++;
      if (anodes[k] == 1'b0) k_low++;
      if (anodes[3:1] != 3'b111) up_low++;
      if (anodes[0] == 1'b0) seg0 = segments;
    end
  endtask

  int         c_any, c_k, c_up;
  logic [6:0] s0;

  initial begin
    reset = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    digit_en = 4'hF; blank_lz = 1'b0; brightness = 4'hF;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Reset mid-slot discards a pending load, without a clock edge.
    @(negedge clock); data_in = 16'h3333; load = 1'b1;
    @(negedge clock); load = 1'b0;
    @(negedge clock);
    chk("pend_before_rst", 16'(pending), 16'd1);
    @(posedge clock); #2 reset = 1'b0; #1;
    chk("rst_anodes", 16'(anodes), 16'hF);
    chk("rst_segments", 16'(segments), 16'h7F);
    chk("rst_dp", 16'(dp), 16'd1);
    chk("rst_pending", 16'(pending), 16'd0);
    chk("rst_tick", 16'(frame_tick), 16'd0);
    @(negedge clock); @(negedge clock); reset = 1'b1;

    // Scan/decode of 12AF.
    @(negedge clock); data_in = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    @(negedge clock); load = 1'b0;
    wait_tick("scan_tick");
    @(negedge clock);
    chk("tick_once", 16'(frame_tick), 16'd0);
    chk("d0_seg_F", 16'(segments), 16'(7'b0001110));
    chk("d0_an", 16'(anodes), 16'(4'b1110));
    chk("d0_dp_off", 16'(dp), 16'd1);
    repeat (4) @(negedge clock);
    chk("d1_seg_A", 16'(segments), 16'(7'b0001000));
    chk("d1_an", 16'(anodes), 16'(4'b1101));
    repeat (4) @(negedge clock);
    chk("d2_seg_2", 16'(segments), 16'(7'b0100100));
    chk("d2_an", 16'(anodes), 16'(4'b1011));
    chk("d2_dp_on", 16'(dp), 16'd0);

    // Tear-free load of 0007 while digit 2 is showing.
    data_in = 16'h0007; dp_in = 4'b0000; load = 1'b1;
    @(negedge clock); load = 1'b0;
    repeat (3) @(negedge clock);
    chk("d3_still_1", 16'(segments), 16'(7'b1111001));
    chk("d3_an", 16'(anodes), 16'(4'b0111));
    chk("tear_pending", 16'(pending), 16'd1);
    wait_tick("tear_tick");
    chk("tear_pend_clr", 16'(pending), 16'd0);
    @(negedge clock);
    chk("d0_seg_7", 16'(segments), 16'(7'b1111000));
    chk("d0_an_7", 16'(anodes), 16'(4'b1110));

    // Leading-zero blanking.
    blank_lz = 1'b1;
    window(0, c_any, c_k, c_up, s0);
    chk("lz7_upper_low", 16'(c_up), 16'd0);
    chk("lz7_d0_cycles", 16'(c_k), 16'd4);
    chk("lz7_d0_seg", 16'(s0), 16'(7'b1111000));
    data_in = 16'h0000; load = 1'b1;
    @(negedge clock); load = 1'b0;
    wait_tick("lz0_tick");
    window(0, c_any, c_k, c_up, s0);
    chk("lz0_upper_low", 16'(c_up), 16'd0);
    chk("lz0_d0_cycles", 16'(c_k), 16'd4);
    chk("lz0_d0_seg", 16'(s0), 16'(7'b1000000));

    // Brightness and enable mask.
    blank_lz = 1'b0; data_in = 16'h4321; load = 1'b1;
    @(negedge clock); load = 1'b0;
    wait_tick("br_tick");
    brightness = 4'd3;
    window(0, c_any, c_k, c_up, s0);
    chk("br3_any_low", 16'(c_any), 16'd4);
    chk("br3_d0_low", 16'(c_k), 16'd4);
    digit_en = 4'b1110;
    window(0, c_any, c_k, c_up, s0);
    chk("br3_en_d0_low", 16'(c_k), 16'd0);
    chk("br3_en_any_low", 16'(c_any), 16'd0);
    brightness = 4'd7; digit_en = 4'hF;
    window(1, c_any, c_k, c_up, s0);
    chk("br7_any_low", 16'(c_any), 16'd8);
    chk("br7_d1_low", 16'(c_k), 16'd4);
    brightness = 4'hF;

    // Load on the same edge as a commit.
    data_in = 16'hABCD; load = 1'b1;
    @(negedge clock); load = 1'b0;
    wait_tick("co_ref_tick");
    @(negedge clock); data_in = 16'h1111; load = 1'b1;
    @(negedge clock); load = 1'b0;
    repeat (13) @(negedge clock);
    data_in = 16'h2222; load = 1'b1;
    @(negedge clock); load = 1'b0;
    chk("co_tick", 16'(frame_tick), 16'd1);
    chk("co_pending", 16'(pending), 16'd1);
    @(negedge clock);
    chk("co_d0_1", 16'(segments), 16'(7'b1111001));
    wait_tick("co_next_tick");
    chk("co_pend_clr", 16'(pending), 16'd0);
    @(negedge clock);
    chk("co_d0_2", 16'(segments), 16'(7'b0100100));

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
